// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and helpers for the two-requester SRAM port arbiter.
// Payload container widths bound the top-level ADDR_WIDTH/DATA_WIDTH parameters.
package sram_port_arbiter_pkg;

    typedef enum logic {
        ID_A = 1'b0,
        ID_B = 1'b1
    } req_id_e;

    localparam int REQ_ADDR_W = 11;
    localparam int REQ_DATA_W = 32;

    typedef struct packed {
        logic                    we;
        logic [REQ_DATA_W/8-1:0] wem;
        logic [REQ_ADDR_W-1:0]   addr;
        logic [REQ_DATA_W-1:0]   wdata;
    } req_payload_t;

    function automatic int rd_lat(input int pipe);
        return 1 + pipe;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// One requester's access port: held request/payload, combinational grant, read response.
// Responses are never stalled; the requester must always accept them.
interface sram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] wem;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, we, wem, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, wem, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer flips after every grant.
// Zero latency; a losing requester simply holds its request until the pointer favours it.
module rr_arb2
    import sram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_e rr;

    assign gnt[0] = ~rst & req[0] & (~req[1] | (rr == ID_A));
    assign gnt[1] = ~rst & req[1] & (~req[0] | (rr == ID_B));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= ID_A;
        end else if (gnt[0]) begin
            rr <= ID_B;
        end else if (gnt[1]) begin
            rr <= ID_A;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates two requesters onto one single-port RAM and steers read data back by id.
// Reads return after 1+PIPE cycles in issue order; responses cannot be backpressured.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = REQ_ADDR_W,
    parameter int DATA_WIDTH = REQ_DATA_W,
    parameter int PIPE       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_port_arbiter_if.slave      a,
    sram_port_arbiter_if.slave      b,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [DATA_WIDTH/8-1:0] ram_wem,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    input  logic [DATA_WIDTH-1:0]   ram_dout,
    output logic                    ram_pipen
);

    localparam int RD_LAT = rd_lat(PIPE);
    localparam int WEM_W  = DATA_WIDTH / 8;

    logic [1:0]   req;
    logic [1:0]   gnt;
    req_payload_t pay_a;
    req_payload_t pay_b;
    req_payload_t pay_sel;

    assign req = {b.req, a.req};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign a.gnt = gnt[0];
    assign b.gnt = gnt[1];

    assign pay_a = '{we: a.we, wem: (REQ_DATA_W/8)'(a.wem), addr: REQ_ADDR_W'(a.addr),
                     wdata: REQ_DATA_W'(a.wdata)};
    assign pay_b = '{we: b.we, wem: (REQ_DATA_W/8)'(b.wem), addr: REQ_ADDR_W'(b.addr),
                     wdata: REQ_DATA_W'(b.wdata)};

    // An idle port drives an all-zero payload so the RAM sees no stray enables.
    always_comb begin
        pay_sel = '0;
        if (gnt[0]) begin
            pay_sel = pay_a;
        end else if (gnt[1]) begin
            pay_sel = pay_b;
        end
    end

    assign ram_en    = |gnt;
    assign ram_we    = pay_sel.we;
    assign ram_wem   = pay_sel.we ? WEM_W'(pay_sel.wem) : '0;
    assign ram_addr  = ADDR_WIDTH'(pay_sel.addr);
    assign ram_din   = DATA_WIDTH'(pay_sel.wdata);
    assign ram_pipen = 1'(PIPE);

    logic [RD_LAT-1:0] trk_vld;
    req_id_e           trk_id [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                trk_id[i] <= ID_A;
            end
        end else begin
            trk_vld[0] <= ram_en & ~ram_we;
            trk_id[0]  <= gnt[1] ? ID_B : ID_A;
            for (int i = 1; i < RD_LAT; i++) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_id[i]  <= trk_id[i-1];
            end
        end
    end

    logic    rsp_vld;
    req_id_e rsp_id;

    assign rsp_vld  = trk_vld[RD_LAT-1];
    assign rsp_id   = trk_id[RD_LAT-1];

    assign a.rvalid = rsp_vld & (rsp_id == ID_A);
    assign b.rvalid = rsp_vld & (rsp_id == ID_B);
    assign a.rdata  = a.rvalid ? ram_dout : '0;
    assign b.rdata  = b.rvalid ? ram_dout : '0;

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter and sequencer for one single-port, byte-write-masked block RAM (`SingleRAM_WEM_FPGA`).
- Grants at most one access per cycle using round-robin priority and drives the RAM port, including its output-pipeline select.
- Tracks in-flight reads and routes each read result back to the requester that issued it, at a fixed latency.
- Sits between two datapath masters (e.g. DMA and core load/store) and one shared local memory bank.

## Interface
Parameters:
- ADDR_WIDTH, 11, RAM word-address width
- DATA_WIDTH, 32, data width; multiple of 8
- PIPE, 0, 0 = 1-cycle RAM read latency, 1 = 2-cycle (drives ram_pipen)

Ports (x = a, b; one identical set per requester):
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- x_req  in  1  access request; held with payload stable until granted
- x_gnt  out  1  combinational grant; request accepted in any cycle where x_req & x_gnt
- x_we  in  1  1 = write, 0 = read
- x_wem  in  DATA_WIDTH/8  byte write mask (writes only)
- x_addr  in  ADDR_WIDTH  word address
- x_wdata  in  DATA_WIDTH  write data
- x_rvalid  out  1  read data valid, one-cycle pulse
- x_rdata  out  DATA_WIDTH  read data; 0 when x_rvalid=0
- ram_en, ram_we  out  1  RAM enable / write enable
- ram_wem  out  DATA_WIDTH/8  RAM byte mask
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM read data
- ram_pipen  out  1  constant PIPE

## Operation
- Arbitration, evaluated every cycle:
  - Only one requester active: it is granted.
  - Both active: the requester named by the round-robin pointer `rr` is granted.
  - After each grant, `rr` points to the other requester. With no grant, `rr` is held.
- RAM port drive:
  - Combinational mux of the granted requester's payload.
  - ram_en = any grant; ram_we = granted x_we.
  - ram_wem = granted x_wem when writing, otherwise 0.
  - With no grant, all ram_* outputs except ram_pipen are 0.
- Read tracking:
  - A shift register of depth 1+PIPE carries {valid, id} for each granted read.
  - Writes enter valid=0 and produce no response.
  - At the output stage, x_rvalid = valid & (id==x); x_rdata = ram_dout when that holds, otherwise 0.
- Write with x_wem = 0 is still granted and consumes a RAM cycle; memory is unchanged.
- Back-to-back accesses:
  - One access is issued per cycle with no bubbles.
  - A read issued the cycle after a write to the same address returns the new data.
  - Read and write in the same cycle cannot occur (single port).
- Requesters must not make x_req depend on x_gnt (no combinational loop).

## Timing
- Reset values:
  - x_gnt = 0 while rst = 1, regardless of x_req.
  - x_rvalid = 0, x_rdata = 0; all ram_* = 0 except ram_pipen = PIPE.
  - rr = a; tracking pipeline cleared.
- Read latency: a read accepted in cycle N yields x_rvalid in cycle N+1+PIPE. Responses return in issue order and are never stalled; requesters must always accept them.
- Throughput: 1 access per cycle aggregate. Under continuous contention each requester gets exactly every other cycle.
- Reset mid-operation: in-flight reads are discarded, with no x_rvalid after the reset cycle. The RAM itself is not cleared.
- A request dropped before being granted is legal and leaves no state behind.

## Structure
- Shared package:
  - Requester-ID encoding (ID_A = 0, ID_B = 1).
  - Latency constant derivation, RD_LAT = 1+PIPE.
  - Request payload struct {we, wem, addr, wdata}, so additional requesters reuse it.
- One natural sub-module: `rr_arb2`, a 2-way round-robin arbiter holding rr.
- Top level holds the payload mux and read-tracking pipeline. It is instantiated alongside `SingleRAM_WEM_FPGA` with matching ADDR_WIDTH/DATA_WIDTH.

## Test plan
- Reset, then a alone:
  - Write addr 0x10 data 0xDEADBEEF with wem 0xF, then read 0x10.
  - Response: a_rvalid at +1 cycle (PIPE=0) and +2 (PIPE=1), data 0xDEADBEEF; b_rvalid never asserted.
- Byte mask:
  - Write 0x11223344 at 0x20 with wem 0xF, then 0xAABBCCDD with wem 0x5, then read.
  - Returns 0x11BB33DD.
- Contention:
  - a and b request reads continuously for 8 cycles.
  - Grants alternate a, b, a, b… starting with a after reset; each rvalid goes to the correct requester with its own address's data.
- Back-to-back write then read to the same address from different requesters: the read returns the written value; no idle cycle is inserted.
- Reset asserted one cycle after a read grant with PIPE=1: no x_rvalid in the following cycles, rr = a afterwards.
- Write with wem = 0x0 at 0x30 holding 0x55555555: grant given, later read returns 0x55555555.
